// File: rtl/add_mul_result_acc.sv
// add_mul_result_acc: collects 8-bit add/multiply datapath results into blocks.
// Each accepted beat adds its result to a saturating accumulator. A block closes
// after BLOCK_LEN beats, or early on flush. One summary record (sum, beat count,
// multiply count, saturation flag) is then offered downstream. No new beats are
// accepted until that record has been taken.
module add_mul_result_acc #(
    parameter int ACC_W     = 12,
    parameter int BLOCK_LEN = 4,
    parameter int CNT_W     = $clog2(BLOCK_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_result,
    input  logic             in_op,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic [CNT_W-1:0] out_mul_cnt,
    output logic             out_sat
);

    typedef enum logic {
        ACCUM = 1'b0,
        EMIT  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] BLOCK_LEN_C = CNT_W'(BLOCK_LEN);

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   mcnt_q, mcnt_d;
    logic               sat_q, sat_d;
    logic               beat;
    logic [ACC_W:0]     add_res;

    // One bit wider than the accumulator so the carry out marks overflow;
    // returns {overflow, clamped_sum}.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [7:0]       r);
        logic [ACC_W:0] s;
        s = {1'b0, a} + (ACC_W + 1)'(r);
        if (s[ACC_W]) begin
            sat_add = {1'b1, {ACC_W{1'b1}}};
        end else begin
            sat_add = s;
        end
    endfunction

    // in_ready is held low during reset, and it never looks at out_ready.
    assign in_ready = (state_q == ACCUM) & rst_n;
    assign beat     = in_valid & in_ready;

    assign out_valid   = (state_q == EMIT);
    assign out_sum     = acc_q;
    assign out_count   = cnt_q;
    assign out_mul_cnt = mcnt_q;
    assign out_sat     = sat_q;

    // Next-state and next-accumulator logic: absorb beats in ACCUM, clear on record handoff.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        mcnt_d  = mcnt_q;
        sat_d   = sat_q;
        add_res = sat_add(acc_q, in_result);
        case (state_q)
            ACCUM: begin
                if (beat) begin
                    acc_d  = add_res[ACC_W-1:0];
                    sat_d  = sat_q | add_res[ACC_W];
                    cnt_d  = cnt_q + CNT_W'(1);
                    mcnt_d = mcnt_q + CNT_W'(in_op);
                end
                // A flush together with a beat closes the block including that beat.
                if ((beat && (cnt_d == BLOCK_LEN_C)) || (flush && (cnt_d != '0))) begin
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    mcnt_d  = '0;
                    sat_d   = 1'b0;
                    state_d = ACCUM;
                end
            end
        endcase
    end

    // State and block registers; reset discards any partial block or pending record.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            mcnt_q  <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            mcnt_q  <= mcnt_d;
            sat_q   <= sat_d;
        end
    end

endmodule

// File: tb/tb_add_mul_result_acc.sv
// Testbench for add_mul_result_acc: four instances share the input stream.
// u0 uses the default parameters, u1 uses an 8-bit accumulator, and u2/u3 use
// block lengths 1 and 7 with a random handshake against a running-sum model.
module tb_add_mul_result_acc;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_result;
    logic       in_op;
    logic       flush;
    logic       out_ready;

    logic        rdy0, ov0, sat0;
    logic [11:0] sum0;
    logic [2:0]  cnt0, mc0;
    logic        rdy1, ov1, sat1;
    logic [7:0]  sum1;
    logic [2:0]  cnt1, mc1;
    logic        rdy2, ov2, sat2;
    logic [11:0] sum2;
    logic [0:0]  cnt2, mc2;
    logic        rdy3, ov3, sat3;
    logic [11:0] sum3;
    logic [2:0]  cnt3, mc3;

    int checks = 0;
    int errors = 0;
    int m_sum2, m_cnt2, m_mc2, tot2, rec2;
    int m_sum3, m_cnt3, m_mc3, tot3, rec3;

    add_mul_result_acc u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0),
        .in_result(in_result), .in_op(in_op), .flush(flush), .out_valid(ov0),
        .out_ready(out_ready), .out_sum(sum0), .out_count(cnt0),
        .out_mul_cnt(mc0), .out_sat(sat0)
    );

    add_mul_result_acc #(.ACC_W(8)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
        .in_result(in_result), .in_op(in_op), .flush(flush), .out_valid(ov1),
        .out_ready(out_ready), .out_sum(sum1), .out_count(cnt1),
        .out_mul_cnt(mc1), .out_sat(sat1)
    );

    add_mul_result_acc #(.BLOCK_LEN(1)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2),
        .in_result(in_result), .in_op(in_op), .flush(flush), .out_valid(ov2),
        .out_ready(out_ready), .out_sum(sum2), .out_count(cnt2),
        .out_mul_cnt(mc2), .out_sat(sat2)
    );

    add_mul_result_acc #(.BLOCK_LEN(7)) u3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy3),
        .in_result(in_result), .in_op(in_op), .flush(flush), .out_valid(ov3),
        .out_ready(out_ready), .out_sum(sum3), .out_count(cnt3),
        .out_mul_cnt(mc3), .out_sat(sat3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] r, input logic op, input logic fl);
        in_valid  = 1'b1;
        in_result = r;
        in_op     = op;
        flush     = fl;
        step();
        in_valid  = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic rand_cycle(input bit drain);
        if (drain) begin
            in_valid  = 1'b0;
            flush     = 1'b1;
            out_ready = 1'b1;
        end else begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_result = 8'($urandom_range(0, 255));
            in_op     = ($urandom_range(0, 1) == 1);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 31) == 0);
        end
        @(negedge clk);
        if (ov2 && out_ready) begin
            chk("bl1_rec_sum", 32'(sum2), m_sum2);
            chk("bl1_rec_count", 32'(cnt2), m_cnt2);
            chk("bl1_rec_mul", 32'(mc2), m_mc2);
            rec2 += int'(cnt2);
            m_sum2 = 0; m_cnt2 = 0; m_mc2 = 0;
        end
        if (in_valid && rdy2) begin
            m_sum2 += int'(in_result); m_cnt2++; m_mc2 += int'(in_op); tot2++;
        end
        if (ov3 && out_ready) begin
            chk("bl7_rec_sum", 32'(sum3), m_sum3);
            chk("bl7_rec_count", 32'(cnt3), m_cnt3);
            chk("bl7_rec_mul", 32'(mc3), m_mc3);
            rec3 += int'(cnt3);
            m_sum3 = 0; m_cnt3 = 0; m_mc3 = 0;
        end
        if (in_valid && rdy3) begin
            m_sum3 += int'(in_result); m_cnt3++; m_mc3 += int'(in_op); tot3++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_result = 8'd0; in_op = 1'b0;
        flush = 1'b0; out_ready = 1'b1;

        // Reset state
        step();
        step();
        chk("rst_in_ready", 32'(rdy0), 0);
        chk("rst_out_valid", 32'(ov0), 0);
        chk("rst_sum", 32'(sum0), 0);
        chk("rst_count", 32'(cnt0), 0);
        chk("rst_mul", 32'(mc0), 0);
        chk("rst_sat", 32'(sat0), 0);
        rst_n = 1'b1;
        step();
        chk("post_rst_in_ready", 32'(rdy0), 1);

        // Full block 3, 9, 144, 15
        beat(8'd3, 1'b0, 1'b0);
        beat(8'd9, 1'b1, 1'b0);
        beat(8'd144, 1'b1, 1'b0);
        beat(8'd15, 1'b0, 1'b0);
        chk("blk_out_valid", 32'(ov0), 1);
        chk("blk_in_ready", 32'(rdy0), 0);
        chk("blk_sum", 32'(sum0), 171);
        chk("blk_count", 32'(cnt0), 4);
        chk("blk_mul", 32'(mc0), 2);
        chk("blk_sat", 32'(sat0), 0);
        step();
        chk("blk_valid_drop", 32'(ov0), 0);
        chk("blk_ready_back", 32'(rdy0), 1);
        chk("blk_sum_cleared", 32'(sum0), 0);

        // Saturation on the 8-bit accumulator, then sticky flag clears
        for (int i = 0; i < 4; i++) beat(8'd255, 1'b0, 1'b0);
        chk("sat8_sum", 32'(sum1), 255);
        chk("sat8_sat", 32'(sat1), 1);
        chk("sat8_count", 32'(cnt1), 4);
        chk("wide_sum", 32'(sum0), 1020);
        chk("wide_sat", 32'(sat0), 0);
        step();
        for (int i = 0; i < 4; i++) beat(8'd1, 1'b1, 1'b0);
        chk("sat8_next_sum", 32'(sum1), 4);
        chk("sat8_next_sat", 32'(sat1), 0);
        chk("sat8_next_mul", 32'(mc1), 4);
        step();

        // Flush alone, flush with a beat, flush on an empty block
        beat(8'd10, 1'b0, 1'b0);
        beat(8'd20, 1'b0, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_valid", 32'(ov0), 1);
        chk("flush_count", 32'(cnt0), 2);
        chk("flush_sum", 32'(sum0), 30);
        step();
        beat(8'd10, 1'b0, 1'b0);
        beat(8'd20, 1'b0, 1'b0);
        beat(8'd5, 1'b1, 1'b1);
        chk("flush_beat_valid", 32'(ov0), 1);
        chk("flush_beat_count", 32'(cnt0), 3);
        chk("flush_beat_sum", 32'(sum0), 35);
        chk("flush_beat_mul", 32'(mc0), 1);
        step();
        flush = 1'b1;
        step();
        chk("flush_empty_valid", 32'(ov0), 0);
        step();
        flush = 1'b0;
        chk("flush_empty_valid2", 32'(ov0), 0);
        chk("flush_empty_count", 32'(cnt0), 0);

        // Backpressure in EMIT with a beat waiting upstream
        out_ready = 1'b0;
        beat(8'd1, 1'b1, 1'b0);
        beat(8'd2, 1'b0, 1'b0);
        beat(8'd3, 1'b0, 1'b0);
        beat(8'd4, 1'b0, 1'b0);
        in_valid = 1'b1; in_result = 8'd50; in_op = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", 32'(ov0), 1);
            chk("hold_in_ready", 32'(rdy0), 0);
            chk("hold_sum", 32'(sum0), 10);
            chk("hold_count", 32'(cnt0), 4);
            chk("hold_mul", 32'(mc0), 1);
            step();
        end
        out_ready = 1'b1;
        step();
        chk("hold_release_valid", 32'(ov0), 0);
        chk("hold_release_ready", 32'(rdy0), 1);
        chk("hold_release_count", 32'(cnt0), 0);
        step();
        in_valid = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("held_beat_valid", 32'(ov0), 1);
        chk("held_beat_sum", 32'(sum0), 50);
        chk("held_beat_count", 32'(cnt0), 1);
        chk("held_beat_mul", 32'(mc0), 1);
        step();

        // Reset while in EMIT
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) beat(8'd1, 1'b1, 1'b0);
        chk("pre_rst_emit_valid", 32'(ov0), 1);
        rst_n = 1'b0;
        step();
        chk("rst_emit_valid", 32'(ov0), 0);
        chk("rst_emit_sum", 32'(sum0), 0);
        chk("rst_emit_count", 32'(cnt0), 0);
        chk("rst_emit_mul", 32'(mc0), 0);
        chk("rst_emit_in_ready", 32'(rdy0), 0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        chk("rst_emit_ready_back", 32'(rdy0), 1);

        // Reset mid-block with two beats collected
        beat(8'd100, 1'b0, 1'b0);
        beat(8'd100, 1'b0, 1'b0);
        chk("mid_pre_count", 32'(cnt0), 2);
        rst_n = 1'b0;
        step();
        chk("mid_rst_count", 32'(cnt0), 0);
        chk("mid_rst_sum", 32'(sum0), 0);
        rst_n = 1'b1;
        step();
        beat(8'd5, 1'b0, 1'b0);
        beat(8'd6, 1'b0, 1'b1);
        chk("mid_after_valid", 32'(ov0), 1);
        chk("mid_after_sum", 32'(sum0), 11);
        chk("mid_after_count", 32'(cnt0), 2);
        step();

        // Random handshake on BLOCK_LEN 1 and 7 instances
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        m_sum2 = 0; m_cnt2 = 0; m_mc2 = 0; tot2 = 0; rec2 = 0;
        m_sum3 = 0; m_cnt3 = 0; m_mc3 = 0; tot3 = 0; rec3 = 0;
        for (int i = 0; i < 10000; i++) rand_cycle(1'b0);
        for (int i = 0; i < 20; i++) rand_cycle(1'b1);
        flush = 1'b0;
        chk("bl1_beats_conserved", 32'(rec2), 32'(tot2));
        chk("bl7_beats_conserved", 32'(rec3), 32'(tot3));
        chk("bl1_activity", 32'(tot2 > 1000), 1);
        chk("bl7_activity", 32'(tot3 > 1000), 1);
        chk("bl7_drained", 32'(cnt3), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
